// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants: opcodes, fetch FSM states, widths, NOP
package cpu_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    localparam logic [15:0] NOP = 16'h0000;

    localparam logic [3:0] OP_ALU0 = 4'h0;
    localparam logic [3:0] OP_ALU1 = 4'h1;
    localparam logic [3:0] OP_ALU2 = 4'h2;
    localparam logic [3:0] OP_ALU3 = 4'h3;
    localparam logic [3:0] OP_LDA  = 4'h4;
    localparam logic [3:0] OP_LDB  = 4'h5;
    localparam logic [3:0] OP_LDC  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_M1_0 = 4'h8;
    localparam logic [3:0] OP_M1_1 = 4'h9;
    localparam logic [3:0] OP_M1_2 = 4'hA;
    localparam logic [3:0] OP_M1_3 = 4'hB;
    localparam logic [3:0] OP_M1_4 = 4'hC;
    localparam logic [3:0] OP_M1_5 = 4'hD;
    localparam logic [3:0] OP_M1_6 = 4'hE;
    localparam logic [3:0] OP_M1_7 = 4'hF;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_REQ  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_register.sv
// rtl/pc_register.sv - program counter with jump-load priority over increment
module pc_register #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (en) begin
            if (load) begin
                pc_d = load_val;
            end else if (inc) begin
                // natural modulo-2^ADDR_W wrap
                pc_d = pc_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC, IR and imem req/ack handshake with timeout
module instr_fetch_unit #(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              fetch_req,
    input  logic              pc_inc,
    input  logic              pc_load,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [3:0]        opcode,
    output logic [DATA_W-5:0] operand,
    output logic              ir_valid,
    output logic              busy,
    output logic              fetch_err
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  cnt_inc;
    logic              fetch_err_q, fetch_err_d;
    logic [ADDR_W-1:0] jump_target;

    // Jump target is the low ADDR_W bits of ir, zero-extended past the operand field.
    generate
        if (ADDR_W <= DATA_W - 4) begin : g_jt_narrow
            assign jump_target = ir_q[ADDR_W-1:0];
        end else begin : g_jt_wide
            assign jump_target = {{(ADDR_W - (DATA_W - 4)){1'b0}}, ir_q[DATA_W-5:0]};
        end
    endgenerate

    pc_register #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .load    (pc_load),
        .inc     (pc_inc),
        .load_val(jump_target),
        .pc      (pc)
    );

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        cnt_d       = cnt_q;
        fetch_err_d = 1'b0;
        case (state_q)
            FS_IDLE: begin
                // pc here is the pre-increment value even if pc_inc fires this cycle
                if (fetch_req && en) begin
                    state_d    = FS_REQ;
                    addr_d     = pc;
                    ir_valid_d = 1'b0;
                    cnt_d      = '0;
                end
            end
            FS_REQ: begin
                // ack wins over both abort and timeout
                if (imem_ack) begin
                    state_d    = FS_IDLE;
                    ir_d       = imem_rdata;
                    ir_valid_d = 1'b1;
                end else if (!en) begin
                    state_d = FS_IDLE;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_d     = FS_IDLE;
                    ir_d        = DATA_W'(NOP);
                    ir_valid_d  = 1'b0;
                    fetch_err_d = 1'b1;
                    cnt_d       = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = FS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FS_IDLE;
            addr_q      <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            cnt_q       <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            cnt_q       <= cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // The request is level-held for exactly the time the FSM sits in REQ.
    assign imem_req  = (state_q == FS_REQ);
    assign busy      = (state_q == FS_REQ);
    assign imem_addr = addr_q;
    assign ir        = ir_q;
    assign ir_valid  = ir_valid_q;
    assign fetch_err = fetch_err_q;
    assign opcode    = ir_q[DATA_W-1:DATA_W-4];
    assign operand   = ir_q[DATA_W-5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic        en;
    logic        fetch_req;
    logic        pc_inc;
    logic        pc_load;
    logic [7:0]  imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [3:0]  opcode;
    logic [11:0] operand;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(
        .ADDR_W  (8),
        .DATA_W  (16),
        .RESET_PC(0),
        .TIMEOUT (15)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fetch_req (fetch_req),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .imem_addr (imem_addr),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .pc        (pc),
        .ir        (ir),
        .opcode    (opcode),
        .operand   (operand),
        .ir_valid  (ir_valid),
        .busy      (busy),
        .fetch_err (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; fetch_req = 1'b0; pc_inc = 1'b0; pc_load = 1'b0;
        imem_ack = 1'b0; imem_rdata = 16'h0000;
        step(); step();
        rst = 1'b0;

        chk("rst_pc",       32'(pc),        32'h0);
        chk("rst_ir",       32'(ir),        32'h0);
        chk("rst_ir_valid", 32'(ir_valid),  32'h0);
        chk("rst_req",      32'(imem_req),  32'h0);
        chk("rst_addr",     32'(imem_addr), 32'h0);
        chk("rst_busy",     32'(busy),      32'h0);
        chk("rst_err",      32'(fetch_err), 32'h0);

        // basic fetch, ack on first request cycle
        en = 1'b1; fetch_req = 1'b1;
        step();
        chk("t1_req",  32'(imem_req),  32'h1);
        chk("t1_busy", 32'(busy),      32'h1);
        chk("t1_addr", 32'(imem_addr), 32'h0);
        fetch_req = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h4A05;
        step();
        imem_ack = 1'b0;
        chk("t1_ir",       32'(ir),       32'h4A05);
        chk("t1_opcode",   32'(opcode),   32'h4);
        chk("t1_operand",  32'(operand),  32'hA05);
        chk("t1_ir_valid", 32'(ir_valid), 32'h1);
        chk("t1_busy_end", 32'(busy),     32'h0);
        chk("t1_req_end",  32'(imem_req), 32'h0);

        // slow memory at pc=1, stray fetch_req while busy
        pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        chk("t2_pc", 32'(pc), 32'h1);
        fetch_req = 1'b1;
        step();
        chk("t2_req0",   32'(imem_req),  32'h1);
        chk("t2_addr0",  32'(imem_addr), 32'h1);
        chk("t2_irv0",   32'(ir_valid),  32'h0);
        for (int i = 0; i < 5; i++) begin
            fetch_req = (i == 2);
            step();
            chk("t2_req_held",  32'(imem_req),  32'h1);
            chk("t2_addr_held", 32'(imem_addr), 32'h1);
            chk("t2_ir_held",   32'(ir),        32'h4A05);
        end
        fetch_req = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h8123;
        step();
        imem_ack = 1'b0;
        chk("t2_ir",  32'(ir),       32'h8123);
        chk("t2_irv", 32'(ir_valid), 32'h1);
        chk("t2_req", 32'(imem_req), 32'h0);
        step();
        chk("t2_not_queued", 32'(imem_req), 32'h0);
        chk("t2_ir_once",    32'(ir),       32'h8123);

        // timeout after 15 wait cycles, late ack ignored
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("t3_req_first", 32'(imem_req), 32'h1);
        for (int i = 0; i < 14; i++) begin
            step();
            chk("t3_req_wait", 32'(imem_req),  32'h1);
            chk("t3_err_wait", 32'(fetch_err), 32'h0);
        end
        step();
        chk("t3_err",  32'(fetch_err), 32'h1);
        chk("t3_req",  32'(imem_req),  32'h0);
        chk("t3_busy", 32'(busy),      32'h0);
        chk("t3_ir",   32'(ir),        32'h0);
        chk("t3_irv",  32'(ir_valid),  32'h0);
        imem_ack = 1'b1; imem_rdata = 16'hFFFF;
        step();
        imem_ack = 1'b0;
        chk("t3_err_pulse", 32'(fetch_err), 32'h0);
        chk("t3_late_ir",   32'(ir),        32'h0);
        chk("t3_late_irv",  32'(ir_valid),  32'h0);

        // jump beats increment, then wrap at 8'hFF
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h7023;
        step();
        imem_ack = 1'b0;
        chk("t4_ir", 32'(ir), 32'h7023);
        pc_load = 1'b1; pc_inc = 1'b1;
        step();
        pc_load = 1'b0; pc_inc = 1'b0;
        chk("t4_jump", 32'(pc), 32'h23);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h70FF;
        step();
        imem_ack = 1'b0;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        chk("t4_pc_ff", 32'(pc), 32'hFF);
        pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        chk("t4_wrap", 32'(pc), 32'h00);

        // fetch_req + pc_inc together; pc_load during REQ leaves imem_addr alone
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0; imem_ack = 1'b1; imem_rdata = 16'h7005;
        step();
        imem_ack = 1'b0;
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        chk("t5_pc5", 32'(pc), 32'h05);
        fetch_req = 1'b1; pc_inc = 1'b1;
        step();
        fetch_req = 1'b0; pc_inc = 1'b0;
        chk("t5_addr", 32'(imem_addr), 32'h05);
        chk("t5_pc6",  32'(pc),        32'h06);
        pc_load = 1'b1;
        step();
        pc_load = 1'b0;
        chk("t5_pc_load_req", 32'(pc),        32'h05);
        chk("t5_addr_stable", 32'(imem_addr), 32'h05);
        imem_ack = 1'b1; imem_rdata = 16'h1234;
        step();
        imem_ack = 1'b0;
        chk("t5_ir", 32'(ir), 32'h1234);

        // en low gates pc and aborts an in-flight fetch silently
        en = 1'b0; pc_inc = 1'b1;
        step();
        pc_inc = 1'b0;
        chk("en_pc_gated", 32'(pc), 32'h05);
        en = 1'b1; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("en_req", 32'(imem_req), 32'h1);
        en = 1'b0;
        step();
        chk("en_abort_req", 32'(imem_req),  32'h0);
        chk("en_abort_err", 32'(fetch_err), 32'h0);
        chk("en_abort_ir",  32'(ir),        32'h1234);
        en = 1'b1;

        // reset mid-fetch, following ack ignored
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        chk("t6_req", 32'(imem_req), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_req_drop", 32'(imem_req),  32'h0);
        chk("t6_pc",       32'(pc),        32'h0);
        chk("t6_ir",       32'(ir),        32'h0);
        chk("t6_addr",     32'(imem_addr), 32'h0);
        imem_ack = 1'b1; imem_rdata = 16'hABCD;
        step();
        imem_ack = 1'b0;
        chk("t6_ack_ir",  32'(ir),       32'h0);
        chk("t6_ack_irv", 32'(ir_valid), 32'h0);
        chk("t6_ack_req", 32'(imem_req), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
